// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the packet-atomic stream multiplexer.
package stream_mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_t;

endpackage

// File: rtl/stream_mux_rr_pick.sv
// Round-robin picker: first requesting channel after ptr, wrapping.
module rr_pick #(
   parameter int CHANNELS  = 4,
   parameter int SEL_WIDTH = 2
) (
   input  logic [CHANNELS-1:0]  i_req,
   input  logic [SEL_WIDTH-1:0] i_ptr,
   output logic                 o_found,
   output logic [SEL_WIDTH-1:0] o_idx
);

   int w_k;

   // Scan from farthest to nearest so the nearest hit is written last
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_k     = 0;
      for (int i = CHANNELS; i >= 1; i--) begin
         w_k = (int'(i_ptr) + i) % CHANNELS;
         if (i_req[w_k]) begin
            o_found = 1'b1;
            o_idx   = SEL_WIDTH'(w_k);
         end
      end
   end

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream mux with registered output and
// packet-atomic fixed or round-robin channel selection.
module stream_mux
   import stream_mux_pkg::*;
#(
   parameter int BUS_WIDTH = 4,
   parameter int CHANNELS  = 4,
   parameter int SEL_WIDTH = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [CHANNELS*BUS_WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]           in_valid,
   input  logic [CHANNELS-1:0]           in_last,
   output logic [CHANNELS-1:0]           in_ready,
   input  logic                          mode,
   input  logic [SEL_WIDTH-1:0]          sel,
   output logic [BUS_WIDTH-1:0]          q,
   output logic                          q_valid,
   output logic                          q_last,
   input  logic                          q_ready,
   output logic [SEL_WIDTH-1:0]          grant
);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SEL_WIDTH-1:0]   r_ptr;
   logic [SEL_WIDTH-1:0]   r_grant;
   logic [BUS_WIDTH-1:0]   r_q;
   logic                   r_q_valid;
   logic                   r_q_last;

   logic                   w_rr_found;
   logic [SEL_WIDTH-1:0]   w_rr_idx;
   logic                   w_fix_found;
   logic                   w_found;
   logic [SEL_WIDTH-1:0]   w_cand;
   logic [BUS_WIDTH-1:0]   w_data;
   logic                   w_valid;
   logic                   w_last;
   logic                   w_can_load;
   logic                   w_xfer;

   rr_pick #(
      .CHANNELS  (CHANNELS),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_rr_pick (
      .i_req   (in_valid),
      .i_ptr   (r_ptr),
      .o_found (w_rr_found),
      .o_idx   (w_rr_idx)
   );

   // Out-of-range sel simply never matches any channel
   always_comb begin
      w_fix_found = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (int'(sel) == c) w_fix_found = in_valid[c];
      end
      if (r_state == LOCKED) begin
         w_found = 1'b1;
         w_cand  = r_grant;
      end else if (mode == MODE_RR) begin
         w_found = w_rr_found;
         w_cand  = w_rr_idx;
      end else begin
         w_found = w_fix_found;
         w_cand  = sel;
      end
   end

   always_comb begin
      w_data  = '0;
      w_valid = 1'b0;
      w_last  = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (int'(w_cand) == c) begin
            w_data  = in_data[c*BUS_WIDTH +: BUS_WIDTH];
            w_valid = in_valid[c];
            w_last  = in_last[c];
         end
      end
   end

   assign w_can_load = !r_q_valid || q_ready;
   assign w_xfer     = !rst && w_found && w_can_load && w_valid;

   always_comb begin
      in_ready = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         in_ready[c] = !rst && w_found && w_can_load
                       && (int'(w_cand) == c);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_xfer) w_state_nxt = w_last ? UNLOCKED : LOCKED;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= UNLOCKED;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q       <= '0;
         r_q_valid <= 1'b0;
         r_q_last  <= 1'b0;
         r_grant   <= '0;
         r_ptr     <= SEL_WIDTH'(CHANNELS - 1);
      end else if (w_xfer) begin
         r_q       <= w_data;
         r_q_last  <= w_last;
         r_q_valid <= 1'b1;
         r_grant   <= w_cand;
         if (w_last && mode == MODE_RR) r_ptr <= w_cand;
      end else if (q_ready) begin
         r_q_valid <= 1'b0;
      end
   end

   assign q       = r_q;
   assign q_valid = r_q_valid;
   assign q_last  = r_q_last;
   assign grant   = r_grant;

endmodule

// File: tb/tb_stream_mux.sv
// Table-driven cycle-by-cycle check of stream_mux.
module tb_stream_mux;

   localparam int BW = 4;
   localparam int CH = 4;
   localparam int SW = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [CH*BW-1:0] in_data;
   logic [CH-1:0]   in_valid;
   logic [CH-1:0]   in_last;
   logic [CH-1:0]   in_ready;
   logic            mode;
   logic [SW-1:0]   sel;
   logic [BW-1:0]   q;
   logic            q_valid;
   logic            q_last;
   logic            q_ready;
   logic [SW-1:0]   grant;

   always #5 clk = ~clk;

   stream_mux #(
      .BUS_WIDTH (BW),
      .CHANNELS  (CH),
      .SEL_WIDTH (SW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_last  (in_last),
      .in_ready (in_ready),
      .mode     (mode),
      .sel      (sel),
      .q        (q),
      .q_valid  (q_valid),
      .q_last   (q_last),
      .q_ready  (q_ready),
      .grant    (grant)
   );

   typedef struct {
      logic          rst;
      logic          mode;
      logic [SW-1:0] sel;
      logic          qr;
      logic [CH-1:0] v;
      logic [CH-1:0] l;
      logic [15:0]   d;
      logic [CH-1:0] erdy;
      logic          eqv;
      logic [BW-1:0] eq;
      logic          eql;
      logic [SW-1:0] eg;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic add(input logic r, input logic m, input int s,
                      input logic qr, input logic [3:0] v,
                      input logic [3:0] l, input logic [15:0] d,
                      input logic [3:0] erdy, input logic eqv,
                      input int eq, input logic eql, input int eg);
      vec_t t;
      t.rst = r; t.mode = m; t.sel = SW'(s); t.qr = qr;
      t.v = v; t.l = l; t.d = d; t.erdy = erdy;
      t.eqv = eqv; t.eq = BW'(eq); t.eql = eql; t.eg = SW'(eg);
      tbl.push_back(t);
   endtask

   task automatic chk(input int idx, input string nm,
                      input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL vec %0d %s: got %0h want %0h", idx, nm, act, exp);
      end
   endtask

   initial begin
      // rst  m  sel qr  v      l      data      rdy   qv  q   ql  g
      // reset
      add(1, 0, 0, 1, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 0, 0, 0, 0);
      // fixed sel=2, 3-beat packet on ch2
      add(0, 0, 2, 1, 4'b0100, 4'b0000, 16'h0A00, 4'b0100, 1, 'hA, 0, 2);
      add(0, 0, 2, 1, 4'b0100, 4'b0000, 16'h0B00, 4'b0100, 1, 'hB, 0, 2);
      add(0, 0, 2, 1, 4'b0100, 4'b0100, 16'h0C00, 4'b0100, 1, 'hC, 1, 2);
      add(0, 0, 2, 1, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 0, 'hC, 1, 2);
      // round robin, single-beat packets on all channels
      add(0, 1, 0, 1, 4'b1111, 4'b1111, 16'h4321, 4'b0001, 1, 1, 1, 0);
      add(0, 1, 0, 1, 4'b1111, 4'b1111, 16'h4321, 4'b0010, 1, 2, 1, 1);
      add(0, 1, 0, 1, 4'b1111, 4'b1111, 16'h4321, 4'b0100, 1, 3, 1, 2);
      add(0, 1, 0, 1, 4'b1111, 4'b1111, 16'h4321, 4'b1000, 1, 4, 1, 3);
      add(0, 1, 0, 1, 4'b1111, 4'b1111, 16'h4321, 4'b0001, 1, 1, 1, 0);
      // ch1 4-beat packet, ch0 raises valid mid-packet
      add(0, 1, 0, 1, 4'b0010, 4'b0000, 16'h0050, 4'b0010, 1, 5, 0, 1);
      add(0, 1, 0, 1, 4'b0011, 4'b0001, 16'h006E, 4'b0010, 1, 6, 0, 1);
      add(0, 1, 0, 1, 4'b0011, 4'b0001, 16'h007E, 4'b0010, 1, 7, 0, 1);
      add(0, 1, 0, 1, 4'b0111, 4'b0111, 16'h098E, 4'b0010, 1, 8, 1, 1);
      add(0, 1, 0, 1, 4'b0101, 4'b0101, 16'h098E, 4'b0100, 1, 9, 1, 2);
      add(0, 1, 0, 1, 4'b0001, 4'b0001, 16'h098E, 4'b0001, 1, 'hE, 1, 0);
      // backpressure: 5 stalled cycles mid-packet on ch3
      add(0, 1, 0, 1, 4'b1000, 4'b0000, 16'h3000, 4'b1000, 1, 3, 0, 3);
      for (int i = 0; i < 5; i++)
         add(0, 1, 0, 0, 4'b1000, 4'b0000, 16'h4000, 4'b0000, 1, 3, 0, 3);
      add(0, 1, 0, 1, 4'b1000, 4'b1000, 16'h4000, 4'b1000, 1, 4, 1, 3);
      add(0, 1, 0, 1, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 0, 4, 1, 3);
      // sel 2->0 while locked on ch2, then sel=5 out of range
      add(0, 0, 2, 1, 4'b0100, 4'b0000, 16'h0100, 4'b0100, 1, 1, 0, 2);
      add(0, 0, 0, 1, 4'b0101, 4'b0001, 16'h020D, 4'b0100, 1, 2, 0, 2);
      add(0, 0, 0, 1, 4'b0101, 4'b0101, 16'h030D, 4'b0100, 1, 3, 1, 2);
      add(0, 0, 0, 1, 4'b0001, 4'b0001, 16'h000D, 4'b0001, 1, 'hD, 1, 0);
      add(0, 0, 5, 1, 4'b1111, 4'b1111, 16'h4321, 4'b0000, 0, 'hD, 1, 0);
      // reset during 2nd beat of a ch1 packet
      add(0, 1, 0, 1, 4'b0010, 4'b0000, 16'h0070, 4'b0010, 1, 7, 0, 1);
      add(1, 1, 0, 1, 4'b0010, 4'b0000, 16'h0080, 4'b0000, 0, 0, 0, 0);
      add(0, 1, 0, 1, 4'b0011, 4'b0011, 16'h0021, 4'b0001, 1, 1, 1, 0);

      rst = 1'b1; mode = 1'b0; sel = '0; q_ready = 1'b0;
      in_valid = '0; in_last = '0; in_data = '0;
      @(posedge clk); #1;

      for (int i = 0; i < tbl.size(); i++) begin
         rst      = tbl[i].rst;
         mode     = tbl[i].mode;
         sel      = tbl[i].sel;
         q_ready  = tbl[i].qr;
         in_valid = tbl[i].v;
         in_last  = tbl[i].l;
         in_data  = tbl[i].d;
         n_vec++;
         #1;
         chk(i, "in_ready", int'(in_ready), int'(tbl[i].erdy));
         @(posedge clk); #1;
         chk(i, "q_valid", int'(q_valid), int'(tbl[i].eqv));
         chk(i, "q", int'(q), int'(tbl[i].eq));
         chk(i, "q_last", int'(q_last), int'(tbl[i].eql));
         chk(i, "grant", int'(grant), int'(tbl[i].eg));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
